alu_array_4b: RTL and testbench

- Per-stage ALU array directly downstream of the PHV/action crossbar.
- Consumes the crossbar's three 4B operand vectors, the one-cycle-delayed action bus and the 256-bit PHV remainder.
- Executes one ALU op per 4B container and reassembles the modified PHV for the next stage.
- Ready/valid on both sides, with a 2-entry skid so backpressure never drops a PHV.

---
 rtl/alu_array_4b_if.sv | 32 +++
 rtl/alu_array_4b.sv | 140 ++++++++++++++
 tb/tb_alu_array_4b.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_array_4b_if.sv
// Operand/action bundle in, modified PHV out, with ready/valid on both sides.
// master = upstream/downstream environment, slave = the ALU array.
interface alu_array_4b_if #(
    parameter int NUM_CONT   = 64,
    parameter int WIDTH_4B   = 32,
    parameter int ACT_LEN    = 64,
    parameter int REMAIN_LEN = 256
);
    logic                                alu_in_valid;
    logic [NUM_CONT*WIDTH_4B-1:0]        alu_in_4B_1;
    logic [NUM_CONT*WIDTH_4B-1:0]        alu_in_4B_2;
    logic [NUM_CONT*WIDTH_4B-1:0]        alu_in_4B_3;
    logic [REMAIN_LEN-1:0]               phv_remain_data;
    logic [NUM_CONT*ACT_LEN-1:0]         action_in;
    logic                                ready_out;
    logic [NUM_CONT*WIDTH_4B+REMAIN_LEN-1:0] phv_out;
    logic                                phv_out_valid;
    logic                                ready_in;
    logic [31:0]                         pkt_cnt;

    modport master (
        output alu_in_valid, alu_in_4B_1, alu_in_4B_2, alu_in_4B_3,
               phv_remain_data, action_in, ready_in,
        input  ready_out, phv_out, phv_out_valid, pkt_cnt
    );

    modport slave (
        input  alu_in_valid, alu_in_4B_1, alu_in_4B_2, alu_in_4B_3,
               phv_remain_data, action_in, ready_in,
        output ready_out, phv_out, phv_out_valid, pkt_cnt
    );
endinterface

// File: rtl/alu_array_4b.sv
// Per-stage 4B ALU array: one op per container, output register plus skid.
// Optional macro ALU_SATURATE_EN: add/addi clamp to all-ones, sub/subi clamp to 0.
module alu_array_4b_lane #(
    parameter int W       = 32,
    parameter int ACT_LEN = 64
) (
    input  logic [ACT_LEN-1:0] act_i,
    input  logic [W-1:0]       a_i,
    input  logic [W-1:0]       b_i,
    input  logic [W-1:0]       c_i,
    output logic [W-1:0]       res_o
);
    logic [3:0] op;
    logic [W:0] sum;
    logic [W:0] diff;
    logic [W-1:0] add_r;
    logic [W-1:0] sub_r;
    logic       unused_act;

    assign op         = act_i[24:21];
    assign unused_act = ^{act_i[ACT_LEN-1:25], act_i[20:0]};
    // Extra MSB carries the add carry-out / subtract borrow.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

`ifdef ALU_SATURATE_EN
    assign add_r = sum[W]  ? '1 : sum[W-1:0];
    assign sub_r = diff[W] ? '0 : diff[W-1:0];
`else
    logic unused_carry;
    assign unused_carry = sum[W] ^ diff[W];
    assign add_r = sum[W-1:0];
    assign sub_r = diff[W-1:0];
`endif

    always_comb begin
        res_o = c_i;
        case (op)
            4'b0001, 4'b1001:          res_o = add_r;
            4'b0010, 4'b1010:          res_o = sub_r;
            4'b1110:                   res_o = b_i;
            4'b1011, 4'b1000, 4'b0111: res_o = a_i;
            default:                   res_o = c_i;
        endcase
    end
endmodule

module alu_array_4b #(
    parameter int STAGE_ID   = 0,
    parameter int NUM_CONT   = 64,
    parameter int WIDTH_4B   = 32,
    parameter int ACT_LEN    = 64,
    parameter int REMAIN_LEN = 256
) (
    input  logic          clk,
    input  logic          rst,
    alu_array_4b_if.slave bus
);
    localparam int PHV_W = NUM_CONT*WIDTH_4B + REMAIN_LEN;

    if (STAGE_ID < 0 || NUM_CONT < 1 || ACT_LEN < 25) begin : g_bad_cfg
        $error("alu_array_4b: illegal parameterization");
    end

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

    logic [NUM_CONT-1:0][WIDTH_4B-1:0] res;
    logic [PHV_W-1:0] phv_new;
    logic             accept;

    state_e           state_q, state_d;
    logic [PHV_W-1:0] out_q, out_d;
    logic [PHV_W-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic [31:0]      cnt_q, cnt_d;

    for (genvar i = 0; i < NUM_CONT; i++) begin : g_lane
        alu_array_4b_lane #(.W(WIDTH_4B), .ACT_LEN(ACT_LEN)) u_lane (
            .act_i (bus.action_in  [i*ACT_LEN  +: ACT_LEN]),
            .a_i   (bus.alu_in_4B_1[i*WIDTH_4B +: WIDTH_4B]),
            .b_i   (bus.alu_in_4B_2[i*WIDTH_4B +: WIDTH_4B]),
            .c_i   (bus.alu_in_4B_3[i*WIDTH_4B +: WIDTH_4B]),
            .res_o (res[i])
        );
    end

    assign phv_new = {res, bus.phv_remain_data};
    assign accept  = bus.alu_in_valid & rdy_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q + 32'(accept);
        case (state_q)
            S_EMPTY: if (accept) begin
                out_d   = phv_new;
                state_d = S_ONE;
            end
            S_ONE: begin
                if (accept && bus.ready_in) begin
                    out_d = phv_new;
                end else if (accept) begin
                    skid_d  = phv_new;
                    state_d = S_FULL;
                end else if (bus.ready_in) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: if (bus.ready_in) begin
                out_d   = skid_q;
                state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase
        // Ready is registered: it reflects whether the skid will be occupied.
        rdy_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready_out     = rdy_q;
    assign bus.phv_out       = out_q;
    assign bus.phv_out_valid = (state_q != S_EMPTY);
    assign bus.pkt_cnt       = cnt_q;
endmodule

// File: tb/tb_alu_array_4b.sv
// Self-checking bench for alu_array_4b: directed vector table, backpressure and
// reset corner sequences, then randomized traffic against a queue-based model.
module tb_alu_array_4b;
    localparam int NC = 64;
    localparam int W  = 32;
    localparam int AL = 64;
    localparam int RL = 256;
    localparam int PW = NC*W + RL;
`ifdef ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_array_4b_if #(.NUM_CONT(NC), .WIDTH_4B(W), .ACT_LEN(AL), .REMAIN_LEN(RL)) bus ();

    alu_array_4b #(.STAGE_ID(0), .NUM_CONT(NC), .WIDTH_4B(W), .ACT_LEN(AL), .REMAIN_LEN(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        int         cont;
        logic [3:0] op;
        logic [W-1:0] a, b, c, exp_wrap, exp_sat;
    } vec_t;
    vec_t vecs[$];

    logic [PW-1:0] sb[$];
    int unsigned   mcnt = 0;
    bit            mon_en = 0;
    bit            hold_prev = 0;
    logic [PW-1:0] prev_phv;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic cmp_phv(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            for (int k = 0; k < PW/32; k++) begin
                if (got[k*32 +: 32] !== exp[k*32 +: 32]) begin
                    $display("FAIL %s word%0d got=%h expected=%h", name, k, got[k*32 +: 32], exp[k*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    // Reference ALU: plain integer arithmetic on the opcode rules.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] c);
        longint unsigned ua = a, ub = b, lim = 64'd1 << W;
        longint unsigned r;
        case (op)
            4'b0001, 4'b1001: begin
                r = ua + ub;
                if (r >= lim) r = SAT ? lim - 1 : r - lim;
                return W'(r);
            end
            4'b0010, 4'b1010: begin
                if (ua >= ub) r = ua - ub;
                else          r = SAT ? 0 : lim + ua - ub;
                return W'(r);
            end
            4'b1110:                   return b;
            4'b1011, 4'b1000, 4'b0111: return a;
            default:                   return c;
        endcase
    endfunction

    function automatic logic [PW-1:0] model_phv();
        logic [PW-1:0] p;
        p[RL-1:0] = bus.phv_remain_data;
        for (int i = 0; i < NC; i++)
            p[RL + i*W +: W] = ref_alu(bus.action_in[i*AL + 21 +: 4], bus.alu_in_4B_1[i*W +: W],
                                       bus.alu_in_4B_2[i*W +: W], bus.alu_in_4B_3[i*W +: W]);
        return p;
    endfunction

    function automatic logic [W-1:0] rval();
        logic [W-1:0] edges [5];
        edges[0] = '0; edges[1] = 1; edges[2] = '1; edges[3] = 32'hFFFF_FFFE; edges[4] = 32'h8000_0000;
        return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : W'($urandom);
    endfunction

    function automatic logic [3:0] rop();
        logic [3:0] ops [8];
        ops[0] = 4'b0001; ops[1] = 4'b0010; ops[2] = 4'b1001; ops[3] = 4'b1010;
        ops[4] = 4'b1110; ops[5] = 4'b1011; ops[6] = 4'b1000; ops[7] = 4'b0111;
        return ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
    endfunction

    task automatic rand_bundle();
        logic [NC*W-1:0]  a, b, c;
        logic [NC*AL-1:0] act;
        logic [RL-1:0]    rem;
        for (int i = 0; i < NC; i++) begin
            a[i*W +: W] = rval();
            b[i*W +: W] = rval();
            c[i*W +: W] = W'($urandom);
            act[i*AL +: AL] = {$urandom, $urandom};
            act[i*AL + 21 +: 4] = rop();
        end
        for (int k = 0; k < RL/32; k++) rem[k*32 +: 32] = $urandom;
        bus.alu_in_4B_1 = a; bus.alu_in_4B_2 = b; bus.alu_in_4B_3 = c;
        bus.action_in = act; bus.phv_remain_data = rem;
    endtask

    // Scoreboard/monitor: samples on the falling edge, mirroring the next rising-edge handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            check("pkt_cnt", 64'(bus.pkt_cnt), 64'(mcnt));
            if (hold_prev) begin
                check("hold_valid", 64'(bus.phv_out_valid), 64'd1);
                cmp_phv("hold_data", bus.phv_out, prev_phv);
            end
            if (rst) begin
                sb.delete();
                mcnt = 0;
                hold_prev = 0;
            end else begin
                if (bus.phv_out_valid && bus.ready_in) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_unexpected_output got=valid expected=none");
                    end else begin
                        cmp_phv("sb_data", bus.phv_out, sb.pop_front());
                    end
                end
                hold_prev = bus.phv_out_valid && !bus.ready_in;
                prev_phv  = bus.phv_out;
                if (bus.alu_in_valid && bus.ready_out) begin
                    sb.push_back(model_phv());
                    mcnt++;
                end
            end
        end
    end

    task automatic send_rand();
        int n = 0;
        bit acc = 0;
        rand_bundle();
        bus.alu_in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk); acc = bus.ready_out;
            @(posedge clk); #1; n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout got=not_accepted expected=accepted");
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [RL-1:0] rem;
        rand_bundle();
        bus.alu_in_4B_1[v.cont*W +: W] = v.a;
        bus.alu_in_4B_2[v.cont*W +: W] = v.b;
        bus.alu_in_4B_3[v.cont*W +: W] = v.c;
        bus.action_in[v.cont*AL + 21 +: 4] = v.op;
        rem = bus.phv_remain_data;
        bus.alu_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.alu_in_valid = 1'b0;
        @(negedge clk);
        check({v.name, "_latency"}, 64'(bus.phv_out_valid), 64'd1);
        check(v.name, 64'(bus.phv_out[RL + v.cont*W +: W]), 64'(SAT ? v.exp_sat : v.exp_wrap));
        checks++;
        if (bus.phv_out[RL-1:0] !== rem) begin
            errors++;
            $display("FAIL %s_remain got=%h expected=%h", v.name, bus.phv_out[31:0], rem[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1; bus.alu_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    bit rdone;

    initial begin
        bus.alu_in_valid = 0; bus.ready_in = 0;
        bus.alu_in_4B_1 = '0; bus.alu_in_4B_2 = '0; bus.alu_in_4B_3 = '0;
        bus.action_in = '0; bus.phv_remain_data = '0;

        vecs.push_back('{"add",       0, 4'b0001, 32'h5,          32'h3,         32'h77,        32'h8,         32'h8});
        vecs.push_back('{"sub_under", 1, 4'b0010, 32'h1,          32'h2,         32'h77,        32'hFFFFFFFF,  32'h0});
        vecs.push_back('{"set",       5, 4'b1110, 32'h1111,       32'h0000ABCD,  32'h2222,      32'h0000ABCD,  32'h0000ABCD});
        vecs.push_back('{"nop_c",     6, 4'b0000, 32'h3333,       32'h4444,      32'h12345678,  32'h12345678,  32'h12345678});
        vecs.push_back('{"add_over", 63, 4'b0001, 32'hFFFFFFFF,   32'h2,         32'h0,         32'h1,         32'hFFFFFFFF});
        vecs.push_back('{"addi_over",10, 4'b1001, 32'hFFFFFFF0,   32'h20,        32'h0,         32'h10,        32'hFFFFFFFF});
        vecs.push_back('{"subi_under",11,4'b1010, 32'h10,         32'h11,        32'h0,         32'hFFFFFFFF,  32'h0});
        vecs.push_back('{"st_1011",  12, 4'b1011, 32'hDEAD0001,   32'h5,         32'h6,         32'hDEAD0001,  32'hDEAD0001});
        vecs.push_back('{"st_1000",  13, 4'b1000, 32'hBEEF0002,   32'h5,         32'h6,         32'hBEEF0002,  32'hBEEF0002});
        vecs.push_back('{"st_0111",  14, 4'b0111, 32'h0BAD0003,   32'h5,         32'h6,         32'h0BAD0003,  32'h0BAD0003});
        vecs.push_back('{"other_c",  15, 4'b1111, 32'h1,          32'h2,         32'hCAFEF00D,  32'hCAFEF00D,  32'hCAFEF00D});
        vecs.push_back('{"sub",      20, 4'b0010, 32'h100,        32'h1,         32'h0,         32'hFF,        32'hFF});
        vecs.push_back('{"addi",     30, 4'b1001, 32'h7,          32'h8,         32'h0,         32'hF,         32'hF});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.phv_out_valid), 64'd0);
        check("rst_ready", 64'(bus.ready_out), 64'd1);
        check("rst_cnt",   64'(bus.pkt_cnt), 64'd0);
        cmp_phv("rst_phv", bus.phv_out, '0);
        @(posedge clk); #1;
        rst = 1'b0; mon_en = 1'b1; bus.ready_in = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: two accepted, third held until downstream opens
        pulse_rst();
        bus.ready_in = 1'b0;
        send_rand();
        send_rand();
        rand_bundle();
        @(negedge clk);
        check("bp_ready_low", 64'(bus.ready_out), 64'd0);
        check("bp_cnt2", 64'(bus.pkt_cnt), 64'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_ready_held", 64'(bus.ready_out), 64'd0);
        @(posedge clk); #1;
        bus.ready_in = 1'b1;
        begin
            int n = 0;
            bit acc = 0;
            while (!acc && n < 20) begin
                @(negedge clk); acc = bus.ready_out;
                @(posedge clk); #1; n++;
            end
            check("bp_third_accepted", 64'(acc), 64'd1);
        end
        bus.alu_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_cnt3", 64'(bus.pkt_cnt), 64'd3);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Reset while FULL discards everything
        @(posedge clk); #1;
        bus.ready_in = 1'b0;
        send_rand();
        send_rand();
        @(negedge clk);
        check("full_ready_low", 64'(bus.ready_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; rand_bundle(); bus.alu_in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.alu_in_valid = 1'b0;
        @(negedge clk);
        check("frst_valid", 64'(bus.phv_out_valid), 64'd0);
        check("frst_ready", 64'(bus.ready_out), 64'd1);
        check("frst_cnt",   64'(bus.pkt_cnt), 64'd0);

        // Reset wins over an accept in the same cycle
        @(posedge clk); #1;
        rst = 1'b1; rand_bundle(); bus.alu_in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.alu_in_valid = 1'b0;
        @(negedge clk);
        check("rprio_valid", 64'(bus.phv_out_valid), 64'd0);
        check("rprio_cnt",   64'(bus.pkt_cnt), 64'd0);
        @(posedge clk); #1;
        bus.ready_in = 1'b1;
        run_vec(vecs[0]);

        // Randomized traffic with random backpressure
        rdone = 0;
        fork
            begin
                for (int s = 0; s < 300; s++) begin
                    send_rand();
                    if ($urandom_range(0, 3) == 0) begin
                        bus.alu_in_valid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                bus.alu_in_valid = 1'b0;
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    bus.ready_in = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        bus.ready_in = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("final_drained", 64'(sb.size()), 64'd0);
        check("final_valid", 64'(bus.phv_out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
